seq_alu: RTL and testbench

Parametrised multi-cycle integer ALU that replaces the combinational add/sub/mul/div/mod breadboard datapath. It keeps the same 4-bit opcode map and 2-bit error encoding, and adds a start/busy/done handshake. Multiply uses an iterative shift-add datapath; divide and modulo use a restoring divider, so large WIDTH closes timing. It sits between the opcode decoder/sequencer and the result register file.

---
 rtl/seq_alu.sv | 194 +++++++++++++++++++
 tb/tb_seq_alu.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Multi-cycle integer ALU: ADD/SUB in one step, shift-add MUL and restoring DIV/MOD over WIDTH steps.
// Define SEQ_ALU_SIGNED_EN to add the sgn port and two's-complement operation.
module seq_alu #(
  parameter  int WIDTH = 16,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
`ifdef SEQ_ALU_SIGNED_EN
  input  logic               sgn,
`endif
  input  logic               start,
  input  logic [3:0]         opcode,
  input  logic [WIDTH-1:0]   input1,
  input  logic [WIDTH-1:0]   input2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic [1:0]         error
);

  localparam int RW = 2 * WIDTH;

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_MOD = 4'd5;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t           state_q;
  logic             busy_q, done_q;
  logic [RW-1:0]    result_q;
  logic [1:0]       error_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       op_q;
  logic [RW-1:0]    a_q;    // MUL: shifting multiplicand; DIV/MOD: dividend/quotient in low bits
  logic [WIDTH-1:0] b_q;    // MUL: shifting multiplier; DIV/MOD: divisor
  logic [RW-1:0]    acc_q;  // MUL: partial product; DIV/MOD: partial remainder in low bits
  logic             neg_q, sgn_q;

  logic sgn_in;
`ifdef SEQ_ALU_SIGNED_EN
  assign sgn_in = sgn;
`else
  assign sgn_in = 1'b0;
`endif

  // True when the upper WIDTH+1 bits of a 2*WIDTH result are a pure sign extension.
  function automatic logic fits_signed(input logic [WIDTH:0] top);
    return (top == '0) || (top == '1);
  endfunction

  logic             neg1, neg2;
  logic [WIDTH-1:0] mag1, mag2;
  logic [RW-1:0]    ext1, ext2, sum_w, diff_w;
  logic             add_ovf, sub_ovf;

  assign neg1    = sgn_in & input1[WIDTH-1];
  assign neg2    = sgn_in & input2[WIDTH-1];
  assign mag1    = neg1 ? -input1 : input1;
  assign mag2    = neg2 ? -input2 : input2;
  assign ext1    = {{WIDTH{neg1}}, input1};
  assign ext2    = {{WIDTH{neg2}}, input2};
  assign sum_w   = ext1 + ext2;
  assign diff_w  = ext1 - ext2;
  assign add_ovf = sgn_in ? !fits_signed(sum_w[RW-1:WIDTH-1]) : sum_w[WIDTH];
  assign sub_ovf = sgn_in ? !fits_signed(diff_w[RW-1:WIDTH-1]) : (input2 > input1);

  logic [RW-1:0]    mul_acc_d;
  logic [WIDTH:0]   div_sh, div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_d, div_quo_d;

  assign mul_acc_d = acc_q + (b_q[0] ? a_q : '0);
  assign div_sh    = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
  assign div_sub   = div_sh - {1'b0, b_q};
  // No borrow out of the trial subtraction means the shifted remainder covers the divisor.
  assign div_ge    = !div_sub[WIDTH];
  assign div_rem_d = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign div_quo_d = {a_q[WIDTH-2:0], div_ge};

  logic [RW-1:0] raw_res, fin_res;
  logic          fin_ovf;

  // NOTE: every always_comb output is assigned on all paths so no latch is inferred.
  always_comb begin
    case (op_q)
      OP_MUL:  raw_res = mul_acc_d;
      OP_DIV:  raw_res = {{WIDTH{1'b0}}, div_quo_d};
      default: raw_res = {{WIDTH{1'b0}}, div_rem_d};
    endcase
    fin_res = neg_q ? -raw_res : raw_res;
    fin_ovf = sgn_q ? !fits_signed(fin_res[RW-1:WIDTH-1])
                    : ((op_q == OP_MUL) && (raw_res[RW-1:WIDTH] != '0));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are reset too; they are few and it keeps simulation X-free.
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      error_q  <= 2'b00;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      sgn_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q  <= opcode;
            cnt_q <= '0;
            acc_q <= '0;
            a_q   <= {{WIDTH{1'b0}}, mag1};
            b_q   <= mag2;
            sgn_q <= sgn_in;
            neg_q <= (opcode == OP_MOD) ? neg1 : (neg1 ^ neg2);
            case (opcode)
              OP_ADD: begin
                result_q <= sum_w;
                error_q  <= {1'b0, add_ovf};
                done_q   <= 1'b1;
                state_q  <= S_FIN;
              end
              OP_SUB: begin
                result_q <= diff_w;
                error_q  <= {1'b0, sub_ovf};
                done_q   <= 1'b1;
                state_q  <= S_FIN;
              end
              OP_MUL: begin
                busy_q  <= 1'b1;
                state_q <= S_CALC;
              end
              OP_DIV, OP_MOD: begin
                if (input2 == '0) begin
                  result_q <= '0;
                  error_q  <= 2'b10;
                  done_q   <= 1'b1;
                  state_q  <= S_FIN;
                end else begin
                  busy_q  <= 1'b1;
                  state_q <= S_CALC;
                end
              end
              default: begin
                result_q <= '0;
                error_q  <= 2'b00;
                done_q   <= 1'b1;
                state_q  <= S_FIN;
              end
            endcase
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q + CW'(1);
          if (op_q == OP_MUL) begin
            acc_q <= mul_acc_d;
            a_q   <= {a_q[RW-2:0], 1'b0};
            b_q   <= {1'b0, b_q[WIDTH-1:1]};
          end else begin
            acc_q <= {{WIDTH{1'b0}}, div_rem_d};
            a_q   <= {{WIDTH{1'b0}}, div_quo_d};
          end
          if (cnt_q == CW'(WIDTH - 1)) begin
            result_q <= fin_res;
            error_q  <= {1'b0, fin_ovf};
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_FIN;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign error  = error_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=16): vector table plus multi-cycle corner sequences.
module tb_seq_alu;

  localparam int W  = 16;
  localparam int RW = 2 * W;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [3:0]    opcode;
  logic [W-1:0]  input1, input2;
  logic          busy, done;
  logic [RW-1:0] result;
  logic [1:0]    error;
`ifdef SEQ_ALU_SIGNED_EN
  logic          sgn = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
`ifdef SEQ_ALU_SIGNED_EN
    .sgn    (sgn),
`endif
    .start  (start),
    .opcode (opcode),
    .input1 (input1),
    .input2 (input2),
    .busy   (busy),
    .done   (done),
    .result (result),
    .error  (error)
  );

  typedef struct {
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [RW-1:0] res;
    logic [1:0]    err;
    int            lat;
    string         name;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present an operation for one accept edge, then scramble the inputs to prove they were latched.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    opcode = op;
    input1 = a;
    input2 = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    opcode = ~op;
    input1 = ~a;
    input2 = ~b;
  endtask

  task automatic run_vec(input vec_t v);
    int cycles;
    issue(v.op, v.a, v.b);
    @(negedge clk);
    cycles = 1;
    check({v.name, " busy"}, 64'(busy), 64'(v.lat > 1));
    while (!done && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    check({v.name, " latency"}, done ? 64'(cycles) : 64'(-1), 64'(v.lat));
    check({v.name, " result"}, 64'(result), 64'(v.res));
    check({v.name, " error"}, 64'(error), 64'(v.err));
    @(negedge clk);
    check({v.name, " done pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int cycles;
    int extra;

    vecs[0]  = '{4'd1, 16'd3,     16'd1,     32'h0000_0004, 2'b00, 1,  "add_3_1"};
    vecs[1]  = '{4'd2, 16'd1,     16'd3,     32'hFFFF_FFFE, 2'b01, 1,  "sub_1_3"};
    vecs[2]  = '{4'd2, 16'd3,     16'd1,     32'h0000_0002, 2'b00, 1,  "sub_3_1"};
    vecs[3]  = '{4'd1, 16'hFFFF,  16'd1,     32'h0001_0000, 2'b01, 1,  "add_carry"};
    vecs[4]  = '{4'd3, 16'hFFFF,  16'hFFFF,  32'hFFFE_0001, 2'b01, 17, "mul_max"};
    vecs[5]  = '{4'd3, 16'd123,   16'd45,    32'h0000_159F, 2'b00, 17, "mul_small"};
    vecs[6]  = '{4'd3, 16'h0100,  16'h0100,  32'h0001_0000, 2'b01, 17, "mul_ovf_edge"};
    vecs[7]  = '{4'd4, 16'd100,   16'd7,     32'd14,        2'b00, 17, "div_100_7"};
    vecs[8]  = '{4'd5, 16'd100,   16'd7,     32'd2,         2'b00, 17, "mod_100_7"};
    vecs[9]  = '{4'd4, 16'd7,     16'd100,   32'd0,         2'b00, 17, "div_small"};
    vecs[10] = '{4'd4, 16'hFFFF,  16'd1,     32'h0000_FFFF, 2'b00, 17, "div_by_1"};
    vecs[11] = '{4'd4, 16'd5,     16'd0,     32'd0,         2'b10, 1,  "div_by_0"};
    vecs[12] = '{4'd5, 16'd5,     16'd0,     32'd0,         2'b10, 1,  "mod_by_0"};
    vecs[13] = '{4'd9, 16'd5,     16'd6,     32'd0,         2'b00, 1,  "nop_9"};
    vecs[14] = '{4'd0, 16'hABCD,  16'h1234,  32'd0,         2'b00, 1,  "nop_0"};

    rst = 1'b1; start = 1'b0; opcode = '0; input1 = '0; input2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset busy",   64'(busy),   64'd0);
    check("reset done",   64'(done),   64'd0);
    check("reset result", 64'(result), 64'd0);
    check("reset error",  64'(error),  64'd0);

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // A start pulse while busy must be dropped, and result must hold its old value until done.
    issue(4'd3, 16'hFFFF, 16'hFFFF);
    repeat (3) @(negedge clk);
    check("busy mid-mul", 64'(busy), 64'd1);
    check("result held while busy", 64'(result), 64'(vecs[NV-1].res));
    opcode = 4'd1; input1 = 16'd1; input2 = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 4;
    while (!done && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    check("mul ignore-start latency", done ? 64'(cycles) : 64'(-1), 64'd17);
    check("mul ignore-start result", 64'(result), 64'hFFFE_0001);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("no queued done", 64'(extra), 64'd0);

    // A start held only through the FIN cycle must be dropped.
    issue(4'd1, 16'd3, 16'd1);
    @(negedge clk);
    check("fin done", 64'(done), 64'd1);
    opcode = 4'd1; input1 = 16'd5; input2 = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) extra++;
      @(negedge clk);
    end
    check("start in fin ignored", 64'(extra), 64'd0);
    check("result after fin start", 64'(result), 64'd4);

    // Reset mid-multiply aborts silently; the block then accepts a new operation at once.
    issue(4'd3, 16'hFFFF, 16'hFFFF);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy",   64'(busy),   64'd0);
    check("abort done",   64'(done),   64'd0);
    check("abort result", 64'(result), 64'd0);
    check("abort error",  64'(error),  64'd0);
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("no done after abort", 64'(extra), 64'd0);
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
